// File: rtl/traffic_cmd_sequencer.sv
// traffic_cmd_sequencer: buffers host commands, tracks a shadow mode, and issues legal commands with enforced spacing.
// Optional TRAFFIC_CMD_STATS_EN adds saturating issued/drop counters.
module traffic_cmd_sequencer #(
  parameter int WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 3
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  input  logic [2:0]                    host_cmd_type_i,
  input  logic [WIDTH-1:0]              host_cmd_data_i,
  input  logic                          host_valid_i,
  output logic                          host_ready_o,
  output logic [2:0]                    cmd_type_o,
  output logic [WIDTH-1:0]              cmd_data_o,
  output logic                          cmd_valid_o,
  output logic [1:0]                    mode_o,
  output logic                          drop_o,
`ifdef TRAFFIC_CMD_STATS_EN
  output logic [15:0]                   issued_cnt_o,
  output logic [15:0]                   drop_cnt_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_usedw_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int UW = AW + 1;
  localparam int CW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic {IDLE, GAP} state_t;
  state_t state;
  logic [2:0] type_mem [FIFO_DEPTH];
  logic [WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] gap_cnt;
  logic push, pop, legal;
  logic [2:0] head_type;
  logic [1:0] next_mode;
  // modes: 0 IDLE, 1 NORMAL, 2 NOTRANSITION
  always_comb begin
    host_ready_o = fifo_usedw_o != UW'(FIFO_DEPTH);
    push = host_valid_i && host_ready_o;
    pop = state == IDLE && fifo_usedw_o != '0;
    head_type = type_mem[rd_ptr];
    legal = head_type == 3'd0 ? mode_o != 2'd1 :
            head_type == 3'd1 ? mode_o != 2'd0 :
            head_type == 3'd2 ? mode_o != 2'd2 :
            head_type <= 3'd5 ? mode_o == 2'd2 : 1'b0;
    next_mode = head_type == 3'd0 ? 2'd1 :
                head_type == 3'd1 ? 2'd0 :
                head_type == 3'd2 ? 2'd2 : mode_o;
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      type_mem[wr_ptr] <= host_cmd_type_i;
      data_mem[wr_ptr] <= host_cmd_data_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_usedw_o <= '0;
      state <= IDLE;
      gap_cnt <= '0;
      cmd_valid_o <= 1'b0;
      cmd_type_o <= '0;
      cmd_data_o <= '0;
      drop_o <= 1'b0;
      mode_o <= '0;
    end else begin
      cmd_valid_o <= pop && legal;
      drop_o <= pop && !legal;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_usedw_o <= fifo_usedw_o + UW'(push) - UW'(pop);
      if (pop && legal) begin
        cmd_type_o <= head_type;
        cmd_data_o <= data_mem[rd_ptr];
        mode_o <= next_mode;
        state <= GAP_CYCLES > 0 ? GAP : IDLE;
        gap_cnt <= '0;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
        if (gap_cnt == CW'(GAP_CYCLES - 1)) state <= IDLE;
      end
    end
  end
`ifdef TRAFFIC_CMD_STATS_EN
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      issued_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (cmd_valid_o && issued_cnt_o != 16'hFFFF) issued_cnt_o <= issued_cnt_o + 1'b1;
      if (drop_o && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_traffic_cmd_sequencer.sv
// tb_traffic_cmd_sequencer: scoreboard bench for traffic_cmd_sequencer (default parameters).
module tb_traffic_cmd_sequencer;
  logic clk = 1'b0;
  logic srst = 1'b1;
  logic [2:0] host_type = '0;
  logic [15:0] host_data = '0;
  logic host_valid = 1'b0;
  logic host_ready, cmd_valid, drop;
  logic [2:0] cmd_type;
  logic [15:0] cmd_data;
  logic [1:0] mode;
  logic [2:0] usedw;
`ifdef TRAFFIC_CMD_STATS_EN
  logic [15:0] issued_cnt, drop_cnt;
`endif
  traffic_cmd_sequencer dut (
    .clk_i(clk), .srst_i(srst),
    .host_cmd_type_i(host_type), .host_cmd_data_i(host_data),
    .host_valid_i(host_valid), .host_ready_o(host_ready),
    .cmd_type_o(cmd_type), .cmd_data_o(cmd_data), .cmd_valid_o(cmd_valid),
    .mode_o(mode), .drop_o(drop),
`ifdef TRAFFIC_CMD_STATS_EN
    .issued_cnt_o(issued_cnt), .drop_cnt_o(drop_cnt),
`endif
    .fifo_usedw_o(usedw)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic valid;
    logic drp;
    logic [2:0] t;
    logic [15:0] d;
    logic [1:0] m;
  } exp_t;
  exp_t sb[$];
  int chk = 0;
  int err = 0;
  int cyc = 0;
  int last_strobe = -100;
  int strobe_cyc[$];
  int push_cyc = 0;
  int waits = 0;
  logic [1:0] mdl_mode = '0;
  logic [2:0] mdl_t = '0;
  logic [15:0] mdl_d = '0;
  // advances one cycle, then compares any strobe/drop against the scoreboard head
  task automatic run_cycle();
    exp_t e, got;
    @(negedge clk);
    cyc++;
    if (cmd_valid === 1'b1 || drop === 1'b1) begin
      got = {cmd_valid, drop, cmd_type, cmd_data, mode};
      chk++;
      if (sb.size() == 0) begin
        err++;
        $display("FAIL unexpected_output cyc=%0d got=%h expected=none", cyc, got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          err++;
          $display("FAIL scoreboard cyc=%0d got=%h expected=%h", cyc, got, e);
        end
      end
      if (cmd_valid === 1'b1) begin
        chk++;
        if (cyc - last_strobe < 4) begin
          err++;
          $display("FAIL spacing cyc=%0d got=%0d expected>=4", cyc, cyc - last_strobe);
        end
        last_strobe = cyc;
        strobe_cyc.push_back(cyc);
      end
    end
  endtask
  task automatic push_cmd(input logic [2:0] t, input logic [15:0] d, input bit track);
    bit lg;
    logic [1:0] nm;
    int w;
    host_type = t;
    host_data = d;
    host_valid = 1'b1;
    w = 0;
    while (host_ready !== 1'b1 && w < 50) begin
      run_cycle();
      w++;
      waits++;
    end
    if (w == 50) begin
      chk++;
      err++;
      $display("FAIL ready_timeout got=0 expected=1");
    end
    if (track) begin
      nm = mdl_mode;
      case (t)
        3'd0: begin lg = mdl_mode != 2'd1; nm = 2'd1; end
        3'd1: begin lg = mdl_mode != 2'd0; nm = 2'd0; end
        3'd2: begin lg = mdl_mode != 2'd2; nm = 2'd2; end
        3'd3, 3'd4, 3'd5: lg = mdl_mode == 2'd2;
        default: lg = 1'b0;
      endcase
      if (lg) begin
        mdl_mode = nm;
        mdl_t = t;
        mdl_d = d;
      end
      sb.push_back({lg, !lg, mdl_t, mdl_d, mdl_mode});
    end
    push_cyc = cyc;
    run_cycle();
    host_valid = 1'b0;
  endtask
  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      run_cycle();
      w++;
    end
    chk++;
    if (sb.size() != 0) begin
      err++;
      $display("FAIL drain_timeout got=%0d pending expected=0", sb.size());
    end
    repeat (8) run_cycle();
  endtask
  task automatic do_reset();
    srst = 1'b1;
    run_cycle();
    srst = 1'b0;
    sb.delete();
    strobe_cyc.delete();
    mdl_mode = '0;
    mdl_t = '0;
    mdl_d = '0;
    last_strobe = -100;
  endtask
  task automatic test_reset();
    host_valid = 1'b0;
    srst = 1'b1;
    run_cycle();
    run_cycle();
    chk++;
    if ({usedw, host_ready, cmd_valid, cmd_type, cmd_data, drop, mode} !== {3'd0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 2'd0}) begin
      err++;
      $display("FAIL reset_state got=%h expected=%h", {usedw, host_ready, cmd_valid, cmd_type, cmd_data, drop, mode},
               {3'd0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 2'd0});
    end
    do_reset();
  endtask
  task automatic test_latency();
    int pc;
    do_reset();
    push_cmd(3'd0, 16'h1234, 1'b1);
    pc = push_cyc;
    drain();
    chk++;
    if (strobe_cyc.size() != 1 || strobe_cyc[0] - pc != 2) begin
      err++;
      $display("FAIL latency got=%0d expected=2", strobe_cyc.size() ? strobe_cyc[0] - pc : -1);
    end
    chk++;
    if (mode !== 2'd1) begin
      err++;
      $display("FAIL latency_mode got=%0d expected=1", mode);
    end
  endtask
  task automatic test_illegal();
    do_reset();
    push_cmd(3'd3, 16'd20, 1'b1);
    push_cmd(3'd7, 16'd21, 1'b1);
    drain();
    chk++;
    if (strobe_cyc.size() != 0) begin
      err++;
      $display("FAIL illegal_strobes got=%0d expected=0", strobe_cyc.size());
    end
    chk++;
    if (mode !== 2'd0) begin
      err++;
      $display("FAIL illegal_mode got=%0d expected=0", mode);
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    push_cmd(3'd2, 16'd100, 1'b1);
    push_cmd(3'd3, 16'd7, 1'b1);
    push_cmd(3'd4, 16'd9, 1'b1);
    push_cmd(3'd5, 16'd0, 1'b1);
    drain();
    chk++;
    if (strobe_cyc.size() != 4) begin
      err++;
      $display("FAIL b2b_count got=%0d expected=4", strobe_cyc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        chk++;
        if (strobe_cyc[i] - strobe_cyc[i-1] != 4) begin
          err++;
          $display("FAIL b2b_gap%0d got=%0d expected=4", i, strobe_cyc[i] - strobe_cyc[i-1]);
        end
      end
    end
    chk++;
    if (mode !== 2'd2) begin
      err++;
      $display("FAIL b2b_mode got=%0d expected=2", mode);
    end
  endtask
  task automatic test_full();
    int w0;
    do_reset();
    push_cmd(3'd0, 16'd1, 1'b1);
    push_cmd(3'd1, 16'd2, 1'b1);
    push_cmd(3'd2, 16'd3, 1'b1);
    push_cmd(3'd3, 16'd4, 1'b1);
    push_cmd(3'd6, 16'd5, 1'b1);
    chk++;
    if (usedw !== 3'd4 || host_ready !== 1'b0) begin
      err++;
      $display("FAIL full_state got=usedw%0d/ready%0b expected=usedw4/ready0", usedw, host_ready);
    end
    w0 = waits;
    push_cmd(3'd1, 16'd6, 1'b1);
    chk++;
    if (waits - w0 != 1) begin
      err++;
      $display("FAIL full_recover got=%0d expected=1", waits - w0);
    end
    drain();
    chk++;
    if (strobe_cyc.size() != 5 || mode !== 2'd0) begin
      err++;
      $display("FAIL full_result got=%0d/%0d expected=5/0", strobe_cyc.size(), mode);
    end
  endtask
  task automatic test_redundant();
    do_reset();
    push_cmd(3'd0, 16'd11, 1'b1);
    push_cmd(3'd0, 16'd12, 1'b1);
    push_cmd(3'd1, 16'd13, 1'b1);
    drain();
    chk++;
    if (strobe_cyc.size() != 2 || mode !== 2'd0) begin
      err++;
      $display("FAIL redundant got=%0d/%0d expected=2/0", strobe_cyc.size(), mode);
    end
  endtask
  task automatic test_reset_flush();
    do_reset();
    push_cmd(3'd0, 16'd1, 1'b1);
    push_cmd(3'd0, 16'd2, 1'b0);
    push_cmd(3'd1, 16'd3, 1'b0);
    push_cmd(3'd2, 16'd4, 1'b0);
    chk++;
    if (usedw !== 3'd3 || strobe_cyc.size() != 1) begin
      err++;
      $display("FAIL flush_pre got=%0d/%0d expected=3/1", usedw, strobe_cyc.size());
    end
    do_reset();
    chk++;
    if ({usedw, cmd_valid, cmd_type, cmd_data, drop, mode} !== 24'd0) begin
      err++;
      $display("FAIL flush_state got=%h expected=0", {usedw, cmd_valid, cmd_type, cmd_data, drop, mode});
    end
    repeat (16) run_cycle();
    chk++;
    if (strobe_cyc.size() != 0 || usedw !== 3'd0) begin
      err++;
      $display("FAIL flush_after got=%0d/%0d expected=0/0", strobe_cyc.size(), usedw);
    end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_illegal();
    test_back_to_back();
    test_full();
    test_redundant();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", chk, err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/traffic_cmd_sequencer.md
Name: traffic_cmd_sequencer

Overview:
- Upstream stage of the traffic light controller. Accepts host commands over a valid/ready handshake and buffers them in a small FIFO.
- Tracks a shadow copy of the controller mode. Issues only commands that are legal in that mode, as single-cycle cmd_valid pulses with a programmable minimum spacing.
- Drops illegal or redundant commands and flags each drop.

Parameters:
- WIDTH, 16, width of command data; matches the controller's cmd_data width.
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2.
- GAP_CYCLES, 3, minimum idle cycles between two issued commands; 0 = back-to-back issue allowed.

Ports:
- clk_i  input  1  clock.
- srst_i  input  1  synchronous reset, active-high.
- host_cmd_type_i  input  3  host command type (0..7).
- host_cmd_data_i  input  WIDTH  host command data.
- host_valid_i  input  1  host command valid.
- host_ready_o  output  1  FIFO can accept a command.
- cmd_type_o  output  3  command type to controller.
- cmd_data_o  output  WIDTH  command data to controller.
- cmd_valid_o  output  1  one-cycle issue strobe.
- mode_o  output  2  shadow mode: 0 IDLE, 1 NORMAL, 2 NOTRANSITION.
- drop_o  output  1  one-cycle pulse per dropped command.
- fifo_usedw_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset, with srst_i sampled high:
  - FIFO flushed; usedw 0; host_ready_o 1.
  - cmd_valid_o 0; cmd_type_o 0; cmd_data_o 0; drop_o 0; mode_o 0; FSM to IDLE.
  - Reset mid-operation discards all queued entries and any pending gap.
- Push:
  - Occurs when host_valid_i && host_ready_o.
  - host_ready_o = (usedw != FIFO_DEPTH), combinational from registered usedw.
  - Pointers wrap modulo FIFO_DEPTH.
- Pop: only from FSM state IDLE with usedw != 0, based on registered usedw. Push and pop in the same cycle leave usedw unchanged.
- FSM states: IDLE, GAP.
  - IDLE, FIFO non-empty: pop head and check legality against mode_o.
    - Legal: next cycle cmd_valid_o=1 with cmd_type_o/cmd_data_o = popped entry; mode_o updated in the same cycle; go to GAP if GAP_CYCLES>0, else stay IDLE.
    - Illegal: next cycle drop_o=1, no cmd_valid_o, mode unchanged; stay IDLE, so the next entry can pop on the following cycle.
  - GAP: counter runs 0..GAP_CYCLES-1, then returns to IDLE. No pops while in GAP.
- Legality:
  - type 0 NORMAL: legal if mode != NORMAL; new mode NORMAL.
  - type 1 SHUTDOWN: legal if mode != IDLE; new mode IDLE.
  - type 2 NOTRANSITION: legal if mode != NOTRANSITION; new mode NOTRANSITION.
  - types 3/4/5 SET_GREEN/SET_RED/SET_YELLOW: legal only in NOTRANSITION; mode unchanged.
  - types 6/7: always illegal.
- Data passes through unmodified, including zero; the downstream controller clamps zero.
- Latency: host handshake at cycle N gives cmd_valid_o at N+2 minimum (empty FIFO, FSM in IDLE).
- Spacing: with GAP_CYCLES=G, consecutive cmd_valid_o strobes are >= G+1 cycles apart. Consecutive drops may occur every cycle.
- cmd_type_o/cmd_data_o hold the last issued values while cmd_valid_o=0.
- Full FIFO: host_ready_o=0. A host command held valid is accepted the cycle after a pop.

Optional Feature:
- Macro TRAFFIC_CMD_STATS_EN.
- When defined, adds two output ports, each 16 bits and saturating at 16'hFFFF:
  - issued_cnt_o, incremented on each cmd_valid_o.
  - drop_cnt_o, incremented on each drop_o.
  - Both are cleared by srst_i.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then push type 0 at cycle N with FIFO empty -> cmd_valid_o=1, cmd_type_o=0 at N+2; mode_o=1.
- In IDLE mode, push type 3 with data 16'd20 -> drop_o pulse, no cmd_valid_o, mode_o stays 0.
- Push 2 (NOTRANSITION), 3/d=7, 4/d=9, 5/d=0 back-to-back with GAP_CYCLES=3 -> four strobes spaced exactly 4 cycles apart, data 7, 9, 0 passed unchanged; mode_o=2.
- Hold host_valid_i high with 6 commands, FIFO_DEPTH=4 -> host_ready_o drops after 4 accepted (with no intervening pop), then recovers; no command lost or duplicated; order preserved.
- Push 0, 0 (redundant), 1 -> strobe, drop, strobe; final mode_o=0.
- Assert srst_i while 3 entries are queued and in GAP -> next cycle usedw=0, outputs 0, mode_o=0; no later strobes for the flushed entries.
